uart_text_ctrl: RTL and testbench
=================================

Name: uart_text_ctrl

Overview:
Command sequencer between the UART receiver and the VGA text-mode character buffer. Consumes received bytes and interprets them as printable characters or escape commands (clear screen, set cursor). Maintains the cursor and issues single-cycle write strobes into the character buffer. A hardware clear engine fills the whole buffer with spaces.

Parameters:
COLS, 80, text columns per row (1..255)
ROWS, 30, text rows per screen (1..255)
ADDR_W, 12, character buffer address width; must satisfy COLS*ROWS <= 2**ADDR_W

Ports:
clk_i  input  1  system clock, 40 MHz
rstn_i  input  1  asynchronous active-low reset
rx_valid_i  input  1  level "byte valid" from the UART receiver; may stay high for many cycles per byte
rx_data_i  input  8  received byte; stable while rx_valid_i is high
buf_we_o  output  1  character buffer write strobe, one cycle per write
buf_addr_o  output  ADDR_W  write address = row*COLS + col
buf_data_o  output  8  character code to write
busy_o  output  1  high while the clear engine runs
cur_col_o  output  8  current cursor column
cur_row_o  output  8  current cursor row

Behaviour:
- Reset (asynchronous, rstn_i low): buf_we_o=0, buf_addr_o=0, buf_data_o=0, busy_o=0, cursor=(0,0), FSM=IDLE, pending byte cleared. Reset mid-clear aborts the clear.
- Byte capture: rising-edge detect on rx_valid_i (previous-cycle register, reset 0). Exactly one byte accepted per low-to-high transition, regardless of how long the level stays high.
- Pending register: 1 entry. A byte accepted while busy_o=1 is held and processed on the first cycle after the clear ends. A second byte arriving while one is already held overwrites it.
- Latency: byte accepted in cycle N (edge seen) -> buf_we_o high in cycle N+1 with valid addr/data. Cursor update is visible in cycle N+1.
- FSM states: IDLE, ESC, POS_ROW, POS_COL, CLEAR.
- IDLE, printable byte 0x20..0x7E: write it at the cursor, then advance.
  - Advance: col+1. If col==COLS-1, col=0 and row+1. If row==ROWS-1 as well, row=0. Wraps to top; no scrolling.
- IDLE, 0x0D (CR): col=0.
- IDLE, 0x0A (LF): row+1, wrapping ROWS-1 -> 0. Column unchanged.
- IDLE, 0x08 (BS): col-1, saturating at 0. No write.
- IDLE, 0x1B (ESC): go to ESC.
- IDLE, any other byte: ignored.
- ESC state:
  - 'C' (0x43) -> CLEAR.
  - 'P' (0x50) -> POS_ROW.
  - 0x1B -> stay in ESC.
  - Any other byte -> IDLE, byte discarded.
- POS_ROW: latch the byte as the row -> POS_COL.
- POS_COL: latch the byte as the column.
  - If row<ROWS and col<COLS, cursor = (row, col).
  - Otherwise the cursor is unchanged (invalid command).
  - Either way -> IDLE. Coordinates are raw binary, not ASCII.
- CLEAR:
  - busy_o=1 starting the cycle after the 'C' edge.
  - Writes buf_data_o=0x20 to addresses 0..COLS*ROWS-1 in consecutive cycles, one per cycle.
  - busy_o drops the cycle after the last write; cursor=(0,0); FSM -> IDLE.
- buf_we_o is never high in two cycles for the same command, except during CLEAR.
- Address arithmetic is computed at ADDR_W bits; no overflow for legal parameters.

Optional Feature:
UART_TEXT_CTRL_ERR_CNT_EN
- With it: adds output err_cnt_o [7:0], reset 0, saturating at 255.
- err_cnt_o increments by 1 on each:
  - unknown byte in the ESC state;
  - out-of-range ESC P command;
  - byte overwritten in the pending register.
- Without it: no err_cnt_o port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Reset, then byte 0x41 with rx_valid_i held high 174 cycles -> exactly one buf_we_o pulse, addr 0, data 0x41, one cycle after the edge; cursor (0,1).
- Send 1B 50 02 05, then 42 -> one write: addr 165, data 0x42; cursor (2,6).
- Send 1B 50 1D 4F, then 5A -> write at addr 2399; cursor wraps to (0,0). Then send 1B 50 1E 00 -> cursor unchanged; err_cnt_o=1 when the feature is enabled.
- Send 1B 43 -> busy_o high for 2400 cycles; 2400 writes of 0x20 to addresses 0..2399 in order; cursor (0,0). Send 0x58 mid-clear -> it is written at addr 0 right after busy_o falls.
- Cursor at (3,0): send 08 -> col stays 0. Send 0A -> row 4. Send 0D -> col 0. No buf_we_o for any of these.
- Assert rstn_i low for 1 cycle mid-clear -> all outputs 0 immediately, busy_o=0, cursor (0,0); the next 0x41 is written to addr 0.

Source files
------------

// File: rtl/uart_text_ctrl.sv
// UART-to-text-buffer command sequencer: printable bytes, cursor controls, ESC C (clear), ESC P r c (move).
// Optional error counter output err_cnt_o is enabled by defining UART_TEXT_CTRL_ERR_CNT_EN.
module uart_text_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [7:0]        buf_data_o,
    output logic              busy_o,
    output logic [7:0]        cur_col_o,
    output logic [7:0]        cur_row_o
`ifdef UART_TEXT_CTRL_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_POS_ROW,
        ST_POS_COL,
        ST_CLEAR
    } state_t;

    localparam logic [ADDR_W:0] TOTAL_C    = (ADDR_W+1)'(COLS * ROWS);
    localparam logic [7:0]      LAST_COL_C = 8'(COLS - 1);
    localparam logic [7:0]      LAST_ROW_C = 8'(ROWS - 1);
    localparam logic [7:0]      COLS_C     = 8'(COLS);
    localparam logic [7:0]      ROWS_C     = 8'(ROWS);
    localparam logic [7:0]      CH_ESC     = 8'h1B;
    localparam logic [7:0]      CH_CR      = 8'h0D;
    localparam logic [7:0]      CH_LF      = 8'h0A;
    localparam logic [7:0]      CH_BS      = 8'h08;
    localparam logic [7:0]      CH_C       = 8'h43;
    localparam logic [7:0]      CH_P       = 8'h50;
    localparam logic [7:0]      CH_SPACE   = 8'h20;

    state_t              state_q, state_d;
    logic                rx_prev_q;
    logic                pend_valid_q, pend_valid_d;
    logic [7:0]          pend_data_q, pend_data_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                busy_q, busy_d;
    logic [7:0]          col_q, col_d;
    logic [7:0]          row_q, row_d;
    logic [7:0]          row_lat_q, row_lat_d;
    logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;

    logic                rx_edge;
    logic                proc_valid;
    logic [7:0]          proc_byte;
    logic                printable;
    logic                pos_ok;
    logic                clr_done;
    logic [ADDR_W-1:0]   wr_addr;

    // A held byte always wins over a fresh edge; the fresh edge is then parked in the pending slot.
    assign rx_edge    = rx_valid_i & ~rx_prev_q;
    assign proc_valid = (state_q != ST_CLEAR) && (pend_valid_q || rx_edge);
    assign proc_byte  = pend_valid_q ? pend_data_q : rx_data_i;
    assign printable  = (proc_byte >= 8'h20) && (proc_byte <= 8'h7E);
    assign pos_ok     = (row_lat_q < ROWS_C) && (proc_byte < COLS_C);
    assign clr_done   = (clr_cnt_q == TOTAL_C);
    assign wr_addr    = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (proc_valid && proc_byte == CH_ESC) state_d = ST_ESC;
            end
            ST_ESC: begin
                if (proc_valid) begin
                    if (proc_byte == CH_C)        state_d = ST_CLEAR;
                    else if (proc_byte == CH_P)   state_d = ST_POS_ROW;
                    else if (proc_byte == CH_ESC) state_d = ST_ESC;
                    else                          state_d = ST_IDLE;
                end
            end
            ST_POS_ROW: begin
                if (proc_valid) state_d = ST_POS_COL;
            end
            ST_POS_COL: begin
                if (proc_valid) state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        col_d     = col_q;
        row_d     = row_q;
        row_lat_d = row_lat_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (proc_valid) begin
                    if (printable) begin
                        we_d   = 1'b1;
                        addr_d = wr_addr;
                        data_d = proc_byte;
                        if (col_q == LAST_COL_C) begin
                            col_d = 8'd0;
                            row_d = (row_q == LAST_ROW_C) ? 8'd0 : row_q + 8'd1;
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                    end else if (proc_byte == CH_CR) begin
                        col_d = 8'd0;
                    end else if (proc_byte == CH_LF) begin
                        row_d = (row_q == LAST_ROW_C) ? 8'd0 : row_q + 8'd1;
                    end else if (proc_byte == CH_BS) begin
                        if (col_q != 8'd0) col_d = col_q - 8'd1;
                    end
                end
            end
            ST_ESC: begin
                // The first clear write goes out together with busy rising.
                if (proc_valid && proc_byte == CH_C) begin
                    we_d      = 1'b1;
                    addr_d    = '0;
                    data_d    = CH_SPACE;
                    busy_d    = 1'b1;
                    clr_cnt_d = (ADDR_W+1)'(1);
                end
            end
            ST_POS_ROW: begin
                if (proc_valid) row_lat_d = proc_byte;
            end
            ST_POS_COL: begin
                if (proc_valid && pos_ok) begin
                    row_d = row_lat_q;
                    col_d = proc_byte;
                end
            end
            ST_CLEAR: begin
                if (clr_done) begin
                    busy_d = 1'b0;
                    col_d  = 8'd0;
                    row_d  = 8'd0;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = clr_cnt_q[ADDR_W-1:0];
                    data_d    = CH_SPACE;
                    clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        if (state_q == ST_CLEAR) begin
            if (rx_edge) begin
                pend_valid_d = 1'b1;
                pend_data_d  = rx_data_i;
            end
        end else if (pend_valid_q) begin
            pend_valid_d = rx_edge;
            if (rx_edge) pend_data_d = rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_prev_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= 8'd0;
            busy_q       <= 1'b0;
            col_q        <= 8'd0;
            row_q        <= 8'd0;
            row_lat_q    <= 8'd0;
            clr_cnt_q    <= '0;
        end else begin
            rx_prev_q    <= rx_valid_i;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_lat_q    <= row_lat_d;
            clr_cnt_q    <= clr_cnt_d;
        end
    end

    assign buf_we_o   = we_q;
    assign buf_addr_o = addr_q;
    assign buf_data_o = data_q;
    assign busy_o     = busy_q;
    assign cur_col_o  = col_q;
    assign cur_row_o  = row_q;

`ifdef UART_TEXT_CTRL_ERR_CNT_EN
    logic       err_inc;
    logic [7:0] err_cnt_q;

    always_comb begin
        err_inc = 1'b0;
        if (state_q == ST_CLEAR) begin
            err_inc = rx_edge && pend_valid_q;
        end else if (proc_valid) begin
            if (state_q == ST_ESC)
                err_inc = (proc_byte != CH_C) && (proc_byte != CH_P) && (proc_byte != CH_ESC);
            else if (state_q == ST_POS_COL)
                err_inc = !pos_ok;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_cnt_q <= 8'd0;
        end else if (err_inc && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_text_ctrl.sv
// Randomised bench for uart_text_ctrl with a behavioural screen/cursor model and a write scoreboard.
module tb_uart_text_ctrl;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int TOTAL  = COLS * ROWS;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              busy;
  logic [7:0]        cur_col;
  logic [7:0]        cur_row;
`ifdef UART_TEXT_CTRL_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  uart_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .buf_we_o   (buf_we),
    .buf_addr_o (buf_addr),
    .buf_data_o (buf_data),
    .busy_o     (busy),
    .cur_col_o  (cur_col),
    .cur_row_o  (cur_row)
`ifdef UART_TEXT_CTRL_ERR_CNT_EN
    ,
    .err_cnt_o  (err_cnt)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  int   m_mode;
  int   m_row, m_col, m_lat, m_err;
  int   busy_lo, busy_hi;
  bit   held;
  logic [7:0] held_b;

  logic [ADDR_W+7:0] exp_q[$];
  int                exp_cyc_q[$];
  bit                mon_en = 1'b0;

  task automatic push_wr(input int a, input logic [7:0] d, input int c);
    exp_q.push_back({ADDR_W'(a), d});
    exp_cyc_q.push_back(c);
  endtask

  task automatic model_reset();
    m_mode = 0; m_row = 0; m_col = 0; m_lat = 0; m_err = 0;
    busy_lo = 1; busy_hi = 0; held = 1'b0; held_b = 8'd0;
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic model_proc(input logic [7:0] b, input int pc);
    int lin;
    case (m_mode)
      0: begin
        if (b >= 8'h20 && b <= 8'h7E) begin
          push_wr(m_row * COLS + m_col, b, pc + 1);
          lin   = (m_row * COLS + m_col + 1) % TOTAL;
          m_row = lin / COLS;
          m_col = lin % COLS;
        end else if (b == 8'h0D) begin
          m_col = 0;
        end else if (b == 8'h0A) begin
          m_row = (m_row + 1) % ROWS;
        end else if (b == 8'h08) begin
          if (m_col > 0) m_col = m_col - 1;
        end else if (b == 8'h1B) begin
          m_mode = 1;
        end
      end
      1: begin
        if (b == 8'h43) begin
          busy_lo = pc + 1;
          busy_hi = pc + TOTAL;
          for (int i = 0; i < TOTAL; i++) push_wr(i, 8'h20, pc + 1 + i);
          m_row = 0; m_col = 0; m_mode = 0;
        end else if (b == 8'h50) begin
          m_mode = 2;
        end else if (b != 8'h1B) begin
          m_mode = 0;
          m_err++;
        end
      end
      2: begin
        m_lat  = int'(b);
        m_mode = 3;
      end
      default: begin
        if (m_lat < ROWS && int'(b) < COLS) begin
          m_row = m_lat;
          m_col = int'(b);
        end else begin
          m_err++;
        end
        m_mode = 0;
      end
    endcase
  endtask

  task automatic model_flush();
    if (held) begin
      held = 1'b0;
      model_proc(held_b, busy_hi + 1);
    end
  endtask

  task automatic model_accept(input logic [7:0] b, input int p);
    if (p >= busy_lo && p <= busy_hi) begin
      if (held) m_err++;
      held   = 1'b1;
      held_b = b;
    end else begin
      model_flush();
      model_proc(b, p);
    end
  endtask

  // driver: raise valid for 'hold' sampled cycles, then at least one low cycle
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    model_accept(b, cyc);
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_clear();
    int guard = 0;
    model_flush();
    while ((cyc <= busy_hi + 3 || exp_q.size() != 0) && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 6000) $display("FAIL wait_clear: timed out, %0d writes outstanding", exp_q.size());
    else n_pass++;
  endtask

  // scoreboard: busy window, write timing/address/data, and no stray writes
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (busy !== ((cyc >= busy_lo) && (cyc <= busy_hi)))
        $display("FAIL busy: cycle %0d got %b want %b", cyc, busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      else n_pass++;
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        n_checks++;
        $display("FAIL missed_write: due cycle %0d addr %0d data %h", exp_cyc_q[0], exp_q[0][ADDR_W+7:8], exp_q[0][7:0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        n_checks++;
        if (buf_we !== 1'b1 || {buf_addr, buf_data} !== exp_q[0])
          $display("FAIL write: cycle %0d got we=%b addr=%0d data=%h want addr=%0d data=%h",
                   cyc, buf_we, buf_addr, buf_data, exp_q[0][ADDR_W+7:8], exp_q[0][7:0]);
        else n_pass++;
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end else begin
        n_checks++;
        if (buf_we !== 1'b0) $display("FAIL stray_write: cycle %0d addr=%0d data=%h", cyc, buf_addr, buf_data);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({buf_we, buf_addr, buf_data, busy} !== '0)
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h busy=%b want all 0", buf_we, buf_addr, buf_data, busy);
    else n_pass++;
    n_checks++;
    if (cur_row !== 8'd0 || cur_col !== 8'd0)
      $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
    else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_hold_level();
    send_byte(8'h41, 174);
    repeat (2) @(negedge clk);
    n_checks++;
    if (cur_row !== 8'(m_row) || cur_col !== 8'(m_col))
      $display("FAIL hold_cursor: got (%0d,%0d) want (%0d,%0d)", cur_row, cur_col, m_row, m_col);
    else n_pass++;
  endtask

  task automatic test_set_cursor();
    logic [7:0] seq [5];
    seq = '{8'h1B, 8'h50, 8'h02, 8'h05, 8'h42};
    foreach (seq[i]) send_byte(seq[i], $urandom_range(1, 3));
    n_checks++;
    if (cur_row !== 8'(m_row) || cur_col !== 8'(m_col))
      $display("FAIL set_cursor: got (%0d,%0d) want (%0d,%0d)", cur_row, cur_col, m_row, m_col);
    else n_pass++;
  endtask

  task automatic test_wrap_and_invalid();
    logic [7:0] seq [9];
    seq = '{8'h1B, 8'h50, 8'h1D, 8'h4F, 8'h5A, 8'h1B, 8'h50, 8'h1E, 8'h00};
    for (int i = 0; i < 5; i++) send_byte(seq[i], $urandom_range(1, 3));
    n_checks++;
    if (cur_row !== 8'(m_row) || cur_col !== 8'(m_col))
      $display("FAIL wrap_cursor: got (%0d,%0d) want (%0d,%0d)", cur_row, cur_col, m_row, m_col);
    else n_pass++;
    send_byte(8'h41, 1);
    for (int i = 5; i < 9; i++) send_byte(seq[i], $urandom_range(1, 3));
    n_checks++;
    if (cur_row !== 8'(m_row) || cur_col !== 8'(m_col))
      $display("FAIL invalid_pos_cursor: got (%0d,%0d) want (%0d,%0d)", cur_row, cur_col, m_row, m_col);
    else n_pass++;
`ifdef UART_TEXT_CTRL_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'(m_err)) $display("FAIL err_cnt_invalid_pos: got %0d want %0d", err_cnt, m_err);
    else n_pass++;
`endif
  endtask

  task automatic test_ctrl_chars();
    logic [7:0] seq [7];
    seq = '{8'h1B, 8'h50, 8'h03, 8'h00, 8'h08, 8'h0A, 8'h0D};
    foreach (seq[i]) begin
      send_byte(seq[i], $urandom_range(1, 2));
      if (i >= 3) begin
        n_checks++;
        if (cur_row !== 8'(m_row) || cur_col !== 8'(m_col))
          $display("FAIL ctrl_char_%0d: got (%0d,%0d) want (%0d,%0d)", i, cur_row, cur_col, m_row, m_col);
        else n_pass++;
      end
    end
  endtask

  task automatic test_clear_with_pending();
    send_byte(8'h1B, 1);
    send_byte(8'h43, 2);
    repeat (500) @(negedge clk);
    send_byte(8'h57, 3);
    send_byte(8'h58, 1);
    wait_clear();
    n_checks++;
    if (cur_row !== 8'(m_row) || cur_col !== 8'(m_col))
      $display("FAIL clear_cursor: got (%0d,%0d) want (%0d,%0d)", cur_row, cur_col, m_row, m_col);
    else n_pass++;
`ifdef UART_TEXT_CTRL_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'(m_err)) $display("FAIL err_cnt_overwrite: got %0d want %0d", err_cnt, m_err);
    else n_pass++;
`endif
  endtask

  task automatic test_random_stream();
    logic [7:0] b;
    int guard;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: b = 8'($urandom_range(8'h20, 8'h7E));
        4:          b = 8'h0D;
        5:          b = 8'h0A;
        6:          b = 8'h08;
        7:          b = 8'h1B;
        8:          b = 8'h50;
        default:    b = 8'($urandom_range(0, 255));
      endcase
      if (m_mode == 2) b = 8'($urandom_range(0, 35));
      if (m_mode == 3) b = 8'($urandom_range(0, 85));
      if (m_mode == 1 && b == 8'h43) b = 8'h44;
      send_byte(b, $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n_checks++;
      if (cur_row !== 8'(m_row) || cur_col !== 8'(m_col))
        $display("FAIL random_cursor: byte %0d (%h) got (%0d,%0d) want (%0d,%0d)", n, b, cur_row, cur_col, m_row, m_col);
      else n_pass++;
    end
    guard = 0;
    while (m_mode != 0 && guard < 4) begin
      send_byte(8'h00, 1);
      guard++;
    end
`ifdef UART_TEXT_CTRL_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'((m_err > 255) ? 255 : m_err)) $display("FAIL err_cnt_random: got %0d want %0d", err_cnt, m_err);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_clear();
    send_byte(8'h1B, 1);
    send_byte(8'h43, 1);
    repeat (300) @(negedge clk);
    mon_en = 1'b0;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({buf_we, buf_addr, buf_data, busy, cur_row, cur_col} !== '0)
      $display("FAIL reset_mid_clear: we=%b addr=%0d data=%h busy=%b cursor=(%0d,%0d) want all 0",
               buf_we, buf_addr, buf_data, busy, cur_row, cur_col);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    mon_en = 1'b1;
    send_byte(8'h41, 2);
    repeat (2) @(negedge clk);
    n_checks++;
    if (cur_row !== 8'(m_row) || cur_col !== 8'(m_col))
      $display("FAIL after_reset_cursor: got (%0d,%0d) want (%0d,%0d)", cur_row, cur_col, m_row, m_col);
    else n_pass++;
`ifdef UART_TEXT_CTRL_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'd0) $display("FAIL err_cnt_after_reset: got %0d want 0", err_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_hold_level();
    test_set_cursor();
    test_wrap_and_invalid();
    test_ctrl_chars();
    test_clear_with_pending();
    test_random_stream();
    test_reset_mid_clear();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d expected writes never seen", exp_q.size());
    else n_pass++;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
